// File: rtl/led_frame_scanner.sv
// LED tile frame scanner: fetches a frame of 16-bit pixel words from on-chip memory
// and shifts each word MSB-first onto the LED chain, then pulses the latch.
module led_frame_scanner #(
  parameter int BASE_ADDR    = 0,
  parameter int NUM_WORDS    = 256,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        frame_start,
  output logic [13:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_clken,
  input  logic [15:0] mem_readdata,
  output logic        led_sclk,
  output logic        led_sdata,
  output logic        led_latch,
  output logic        busy,
  output logic        frame_done
);

  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_HIGH   = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_WORDS - 1);
  localparam logic [13:0]   BASE       = 14'(BASE_ADDR);

  // The frame must lie entirely inside the 13000-word pixel memory.
  generate
    if (NUM_WORDS < 1 || BASE_ADDR < 0 || BASE_ADDR + NUM_WORDS - 1 > 12999 ||
        CLK_DIV < 1 || LATCH_CYCLES < 1) begin : g_param_check
      $error("led_frame_scanner: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [LW-1:0] latch_cnt_q, latch_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          mem_clken_q, mem_clken_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      div_q        <= '0;
      latch_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      mem_clken_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      div_q        <= div_d;
      latch_cnt_q  <= latch_cnt_d;
      frame_done_q <= frame_done_d;
      mem_clken_q  <= mem_clken_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    div_d        = div_q;
    latch_cnt_d  = latch_cnt_q;
    frame_done_d = 1'b0;
    mem_clken_d  = 1'b1;

    // Dropping enable abandons the frame; the partially shifted chain is never latched.
    if (!enable) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      div_d       = '0;
      latch_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_d = S_FETCH;
            idx_d   = '0;
          end
        end
        S_FETCH: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          shreg_d  = mem_readdata;
          bitcnt_d = 4'd15;
          div_d    = '0;
          state_d  = S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bitcnt_q != 4'd0) begin
              shreg_d  = {shreg_q[14:0], 1'b0};
              bitcnt_d = bitcnt_q - 4'd1;
            end else begin
              idx_d = idx_q + IW'(1);
              if (idx_q == IDX_LAST) begin
                state_d     = S_LATCH;
                latch_cnt_d = '0;
              end else begin
                state_d = S_FETCH;
              end
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        S_LATCH: begin
          if (latch_cnt_q == LATCH_LAST) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            latch_cnt_d = latch_cnt_q + LW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the state flops directly so an async reset clears them immediately.
  always_comb begin
    mem_chipselect = (state_q == S_FETCH);
    mem_address    = mem_chipselect ? (BASE + 14'(idx_q)) : 14'd0;
    mem_clken      = mem_clken_q;
    led_sclk       = (state_q == S_SHIFT) && (div_q >= DIV_HIGH);
    led_sdata      = (state_q == S_SHIFT) && shreg_q[15];
    led_latch      = (state_q == S_LATCH);
    busy           = (state_q != S_IDLE);
    frame_done     = frame_done_q;
  end

endmodule

// File: tb/tb_led_frame_scanner.sv
// Bench for led_frame_scanner: randomized frames checked by a cycle-stamped event
// scoreboard, plus a fast-divider instance sitting at the top of the address range.
module tb_led_frame_scanner;

  localparam int A_BASE = 100;
  localparam int A_N    = 3;
  localparam int A_CD   = 2;
  localparam int A_L    = 4;
  localparam int A_W    = 2 + 32 * A_CD;
  localparam int A_FL   = 1 + A_N * A_W + A_L;

  logic clk = 1'b0;
  logic reset_n, enable, fs_a, fs_b;

  logic [13:0] a_addr, b_addr;
  logic        a_cs, a_clken, a_sclk, a_sdata, a_latch, a_busy, a_done;
  logic        b_cs, b_clken, b_sclk, b_sdata, b_latch, b_busy, b_done;
  logic [15:0] a_rd, b_rd, b_word;
  logic [15:0] mem_a [0:16383];

  always #5 clk = ~clk;

  led_frame_scanner #(.BASE_ADDR(A_BASE), .NUM_WORDS(A_N), .CLK_DIV(A_CD), .LATCH_CYCLES(A_L)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(fs_a),
    .mem_address(a_addr), .mem_chipselect(a_cs), .mem_clken(a_clken), .mem_readdata(a_rd),
    .led_sclk(a_sclk), .led_sdata(a_sdata), .led_latch(a_latch), .busy(a_busy), .frame_done(a_done)
  );

  led_frame_scanner #(.BASE_ADDR(12999), .NUM_WORDS(1), .CLK_DIV(1), .LATCH_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(fs_b),
    .mem_address(b_addr), .mem_chipselect(b_cs), .mem_clken(b_clken), .mem_readdata(b_rd),
    .led_sclk(b_sclk), .led_sdata(b_sdata), .led_latch(b_latch), .busy(b_busy), .frame_done(b_done)
  );

  // Pixel memories: address registered on the edge, data visible for the following cycle.
  always @(posedge clk) begin
    if (a_cs && a_clken) a_rd <= mem_a[a_addr];
    if (b_cs && b_clken) b_rd <= (b_addr == 14'd12999) ? b_word : 16'h0000;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t addr_q[$];
  ev_t bit_q[$];
  ev_t latch_q[$];
  ev_t done_q[$];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int at);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got event at cycle %0d, expected no event", name, at);
  endtask

  // Reference frame: word i is read at k0+1+i*W and its bit j rises mid-bit;
  // an abort at cycle a keeps only what happens up to and including cycle a.
  task automatic push_frame(input int k0, input int abort_at);
    int  c;
    ev_t e;
    for (int i = 0; i < A_N; i++) begin
      c = k0 + 1 + i * A_W;
      if (abort_at < 0 || c <= abort_at) begin
        e.cyc = c; e.val = A_BASE + i; addr_q.push_back(e);
      end
      for (int j = 0; j < 16; j++) begin
        c = k0 + 1 + i * A_W + 2 + j * 2 * A_CD + A_CD;
        if (abort_at < 0 || c <= abort_at) begin
          e.cyc = c; e.val = int'(mem_a[A_BASE + i][15 - j]); bit_q.push_back(e);
        end
      end
    end
    for (int l = 0; l < A_L; l++) begin
      c = k0 + 1 + A_N * A_W + l;
      if (abort_at < 0 || c <= abort_at) begin
        e.cyc = c; e.val = 1; latch_q.push_back(e);
      end
    end
    c = k0 + A_FL;
    if (abort_at < 0 || abort_at >= c) begin
      e.cyc = c; e.val = 1; done_q.push_back(e);
    end
  endtask

  logic sclk_prev = 1'b0;
  ev_t  mon_e;

  always @(negedge clk) begin
    if (reset_n) begin
      if (a_cs) begin
        if (addr_q.size() == 0) unexpected("read", cyc);
        else begin
          mon_e = addr_q.pop_front();
          check_output("read_cycle", cyc, mon_e.cyc);
          check_output("read_addr", int'(a_addr), mon_e.val);
        end
      end
      if (a_sclk && !sclk_prev) begin
        if (bit_q.size() == 0) unexpected("sclk_rise", cyc);
        else begin
          mon_e = bit_q.pop_front();
          check_output("bit_cycle", cyc, mon_e.cyc);
          check_output("bit_data", int'(a_sdata), mon_e.val);
        end
      end
      if (a_latch) begin
        if (latch_q.size() == 0) unexpected("latch", cyc);
        else begin
          mon_e = latch_q.pop_front();
          check_output("latch_cycle", cyc, mon_e.cyc);
          check_output("latch_sdata", int'(a_sdata), 0);
        end
      end
      if (a_done) begin
        if (done_q.size() == 0) unexpected("frame_done", cyc);
        else begin
          mon_e = done_q.pop_front();
          check_output("done_cycle", cyc, mon_e.cyc);
          check_output("done_busy", int'(a_busy), 0);
        end
      end
    end
    sclk_prev <= reset_n ? a_sclk : 1'b0;
  end

  task automatic check_drained();
    check_output("addr_q_left", addr_q.size(), 0);
    check_output("bit_q_left", bit_q.size(), 0);
    check_output("latch_q_left", latch_q.size(), 0);
    check_output("done_q_left", done_q.size(), 0);
  endtask

  // Runs one frame on dut_a; abort_off<0 means no abort, extra sprinkles ignored start pulses.
  task automatic apply_frame(input int abort_off, input bit extra);
    int k0;
    @(negedge clk);
    fs_a = 1'b1;
    k0   = cyc;
    push_frame(k0, (abort_off < 0) ? -1 : k0 + abort_off);
    @(negedge clk);
    for (int off = 1; off <= A_FL + 3; off++) begin
      fs_a = extra && off < A_FL && (abort_off < 0 || off < abort_off) &&
             ($urandom_range(0, 15) == 0);
      if (off == abort_off) enable = 1'b0;
      if (abort_off >= 0 && off == abort_off + 1) begin
        check_output("abort_outputs", int'({a_busy, a_sclk, a_latch, a_cs, a_sdata}), 0);
        enable = 1'b1;
      end
      @(negedge clk);
    end
    fs_a = 1'b0;
    check_drained();
  endtask

  task automatic randomize_frame_data();
    for (int i = 0; i < A_N; i++) mem_a[A_BASE + i] = 16'($urandom);
  endtask

  task automatic apply_held_start();
    int k0;
    @(negedge clk);
    fs_a = 1'b1;
    k0   = cyc;
    push_frame(k0, -1);
    push_frame(k0 + A_FL, -1);
    @(negedge clk);
    for (int off = 1; off <= 2 * A_FL + 3; off++) begin
      if (off == A_FL + 1) fs_a = 1'b0;
      @(negedge clk);
    end
    check_drained();
  endtask

  task automatic apply_fast_divider();
    int k0;
    int pulses;
    logic exp_sclk;
    pulses = 0;
    @(negedge clk);
    fs_b = 1'b1;
    k0   = cyc;
    @(negedge clk);
    fs_b = 1'b0;
    for (int off = 1; off <= 42; off++) begin
      exp_sclk = (off >= 4 && off <= 34 && off % 2 == 0);
      check_output("b_sclk", int'(b_sclk), int'(exp_sclk));
      if (exp_sclk) begin
        pulses++;
        check_output("b_sdata", int'(b_sdata), int'(b_word[15 - (off - 4) / 2]));
      end
      if (off == 1) check_output("b_addr", int'(b_addr), 12999);
      check_output("b_latch", int'(b_latch), int'(off >= 35 && off <= 38));
      check_output("b_done", int'(b_done), int'(off == 39));
      @(negedge clk);
    end
    check_output("b_pulses", pulses, 16);
    check_output("b_start_cycle", k0 + 43, cyc);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem_a[i] = 16'($urandom);
    mem_a[100] = 16'hA5C3;
    mem_a[101] = 16'h0001;
    mem_a[102] = 16'hFFFF;
    b_word     = 16'($urandom);
    reset_n = 1'b0;
    enable  = 1'b0;
    fs_a    = 1'b0;
    fs_b    = 1'b0;

    repeat (3) @(negedge clk);
    check_output("reset_outputs_a",
                 int'({a_addr, a_cs, a_clken, a_sclk, a_sdata, a_latch, a_busy, a_done}), 0);
    check_output("reset_outputs_b",
                 int'({b_addr, b_cs, b_clken, b_sclk, b_sdata, b_latch, b_busy, b_done}), 0);
    reset_n = 1'b1;
    #1 check_output("clken_before_edge", int'(a_clken), 0);
    @(negedge clk);
    check_output("clken_after_reset", int'(a_clken), 1);
    check_output("busy_after_reset", int'(a_busy), 0);
    enable = 1'b1;

    apply_fast_divider();

    apply_frame(-1, 1'b0);
    apply_frame(-1, 1'b1);
    for (int n = 0; n < 3; n++) begin
      randomize_frame_data();
      apply_frame(-1, 1'b1);
    end

    // Abort somewhere in bit 7 of word 1, then confirm the restart begins at word 0.
    mem_a[100] = 16'hA5C3;
    mem_a[101] = 16'h0001;
    mem_a[102] = 16'hFFFF;
    apply_frame(1 + A_W + 2 + 7 * 2 * A_CD + int'($urandom_range(0, 2 * A_CD - 1)), 1'b1);
    apply_frame(-1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      randomize_frame_data();
      apply_frame(int'($urandom_range(1, A_FL - 1)), 1'b1);
      apply_frame(-1, 1'b0);
    end

    randomize_frame_data();
    apply_held_start();

    // Asynchronous reset landing mid-SHIFT, between clock edges.
    @(negedge clk);
    fs_a = 1'b1;
    push_frame(cyc, -1);
    @(negedge clk);
    fs_a = 1'b0;
    repeat (40) @(negedge clk);
    check_output("busy_before_async_reset", int'(a_busy), 1);
    #2 reset_n = 1'b0;
    #1 check_output("async_reset_outputs",
                    int'({a_addr, a_cs, a_clken, a_sclk, a_sdata, a_latch, a_busy, a_done}), 0);
    addr_q.delete();
    bit_q.delete();
    latch_q.delete();
    done_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_output("idle_after_reset_busy", int'(a_busy), 0);
    check_output("idle_after_reset_clken", int'(a_clken), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_scanner.md
Name: led_frame_scanner

Overview:
- Reads one frame of 16-bit pixel words from the on-chip pixel memory over its read port.
- Serializes each word MSB-first onto the LED tile shift-register chain using a clock/data/latch interface.
- Sits directly downstream of the on-chip memory and drives the LED tile pins.
- Memory timing: single-port, address registered inside the RAM, unregistered output. `mem_readdata` is valid exactly 1 clk after the address is presented with `mem_chipselect`=1 and `mem_clken`=1.

Parameters:
- BASE_ADDR, 0, word address of the first pixel of the frame.
- NUM_WORDS, 256, words per frame. Range 1..13000. BASE_ADDR+NUM_WORDS-1 ≤ 12999, enforced by an elaboration-time check.
- CLK_DIV, 4, clk cycles per `led_sclk` half-period. Must be ≥ 1.
- LATCH_CYCLES, 4, clk cycles `led_latch` is held high. Must be ≥ 1.

Ports:
- clk  in  1  system clock. Sole clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanner enable. Low forces IDLE.
- frame_start  in  1  one-cycle pulse that starts a frame. Sampled in IDLE only.
- mem_address  out  14  word address to pixel memory.
- mem_chipselect  out  1  read strobe to pixel memory.
- mem_clken  out  1  memory clock enable. Constant 1 out of reset.
- mem_readdata  in  16  pixel word from memory.
- led_sclk  out  1  LED chain shift clock. Data is sampled by the chain on its rising edge.
- led_sdata  out  1  LED chain serial data.
- led_latch  out  1  LED chain latch strobe.
- busy  out  1  high from FETCH of word 0 until return to IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes normally.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE; word index = 0; shift register = 0; bit counter = 0; divider = 0.
  - All outputs 0, including `mem_clken`.
  - `mem_clken` goes to 1 on the first clk after reset_n rises.
- States: IDLE, FETCH, CAPTURE, SHIFT, LATCH.
- IDLE:
  - Outputs low.
  - `enable`=1 and `frame_start`=1 → FETCH next cycle, with idx=0.
  - `frame_start` is ignored in every other state.
- FETCH (1 cycle):
  - `mem_chipselect`=1; `mem_address`=BASE_ADDR+idx.
  - Next state is CAPTURE.
- CAPTURE (1 cycle):
  - Load the shift register from `mem_readdata`; bit counter = 15; divider = 0.
  - `mem_chipselect`=0. Next state is SHIFT.
- SHIFT:
  - `led_sdata` = shreg[15] throughout the bit.
  - `led_sclk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the final high cycle of a bit:
    - bit counter > 0: shift the register left by 1 and decrement the bit counter.
    - bit counter = 0: idx increments. idx = NUM_WORDS → LATCH; otherwise → FETCH.
  - `led_sclk` returns low on leaving SHIFT.
- Word period: 2 + 32·CLK_DIV cycles. Gaps between words are permitted; `led_sclk` stays low during FETCH and CAPTURE.
- LATCH:
  - `led_latch`=1 for LATCH_CYCLES cycles; `led_sdata`=0.
  - Then `frame_done`=1 for one cycle, coincident with the transition to IDLE.
  - `busy` drops in that same cycle.
- Frame latency: `frame_start` at cycle 0 → FETCH at cycle 1 → `frame_done` at cycle 1 + NUM_WORDS·(2+32·CLK_DIV) + LATCH_CYCLES.
- `enable` deasserted in any non-IDLE state:
  - Next cycle the state is IDLE and all LED outputs and `mem_chipselect` are 0.
  - No `frame_done`; idx resets to 0.
  - Partial data in the chain is not latched.
- idx width: ceil(log2(NUM_WORDS+1)). Address arithmetic is 14-bit unsigned and never wraps, by the parameter constraint.
- Simultaneous `enable` 0→1 with `frame_start`: the frame starts.
- `frame_start` held high continuously: a new frame starts on the cycle after `frame_done` (IDLE for 1 cycle).
- `mem_readdata` is sampled only in CAPTURE. Values at all other times have no effect.

Test Plan:
- Reset values: CLK_DIV=2, NUM_WORDS=3, BASE_ADDR=100; memory at 100..102 holds 0xA5C3, 0x0001, 0xFFFF. Hold reset_n low → all outputs 0. Release reset_n → `mem_clken`=1 next cycle, `busy`=0.
- Full frame (same setup):
  - `frame_start` pulse at cycle 0 → `mem_address`=100/101/102 with `mem_chipselect` high at cycles 1/67/133.
  - `led_sdata` sampled at `led_sclk` rising edges = 1010010111000011, 0000000000000001, 1111111111111111.
  - `led_latch` high cycles 199–202; `frame_done` at cycle 203 only.
- Clock divider: CLK_DIV=1, NUM_WORDS=1 → 16 `led_sclk` pulses, each 1 high and 1 low cycle; `frame_done` at cycle 1+34+4=39.
- Abort: deassert `enable` during bit 7 of word 1 → next cycle `busy`=0, `led_sclk`=0, `led_latch` never asserted, no `frame_done`. A following `frame_start` restarts at address 100.
- Ignored start: extra `frame_start` pulses mid-frame → no change to addresses or timing versus the full-frame case.
- Async reset mid-SHIFT: reset_n low asynchronously → outputs 0 before the next clk edge. After release, the scanner waits in IDLE.
